// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolve / BHT slice: result codes,
// 2-bit counter states and the wrong-path shadow FSM states.
package branch_pkg;

   localparam logic [1:0] RES_NONE     = 2'b00;
   localparam logic [1:0] RES_HIT      = 2'b01;
   localparam logic [1:0] RES_MISS_DIR = 2'b10;
   localparam logic [1:0] RES_MISS_TGT = 2'b11;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   typedef enum logic {IDLE, SHADOW} state_t;

   // Saturating step of a 2-bit direction counter toward the actual outcome.
   function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
      if (taken) return (ctr == ST) ? ST : ctr + 2'd1;
      else       return (ctr == SNT) ? SNT : ctr - 2'd1;
   endfunction

endpackage

// File: rtl/branch_resolve_bht_counter_array.sv
// Table of 2-bit saturating direction counters with one fetch read port and
// one execute update port; BYPASS forwards a same-cycle update to the read.
module bht_counter_array
   import branch_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int IDX_W  = $clog2(DEPTH),
   parameter int BYPASS = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_taken,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   logic [1:0] ctr_q [DEPTH];
   logic [1:0] upd_next;
   logic [1:0] rd_ctr;

   assign upd_next = sat_update(ctr_q[upd_idx], upd_taken);

   always_comb begin
      rd_ctr = ctr_q[rd_idx];
      if ((BYPASS != 0) && upd_en && (rd_idx == upd_idx)) rd_ctr = upd_next;
   end

   assign rd_taken = rd_ctr[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) ctr_q[i] <= WNT;
      end else if (upd_en) begin
         ctr_q[upd_idx] <= upd_next;
      end
   end

endmodule

// File: rtl/branch_resolve_bht.sv
// Branch resolve unit: classifies executed branches, raises flush/redirect,
// masks wrong-path resolves after a flush and keeps saturating statistics.
module branch_resolve_bht
   import branch_pkg::*;
#(
   parameter int WIDTH_DATA_LENGTH = 32,
   parameter int DEPTH             = 64,
   parameter int FLUSH_CYC         = 2,
   parameter int BYPASS            = 0,
   parameter int CNT_W             = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [WIDTH_DATA_LENGTH-1:0] if_pc,
   output logic                         pred_taken,
   input  logic                         ex_valid,
   input  logic                         ex_is_branch,
   input  logic [WIDTH_DATA_LENGTH-1:0] ex_pc,
   input  logic                         ex_predicted,
   input  logic [WIDTH_DATA_LENGTH-1:0] ex_pc_pre,
   input  logic [WIDTH_DATA_LENGTH-1:0] ex_pc_alu,
   input  logic                         ex_taken,
   input  logic                         stat_clr,
   output logic [1:0]                   result,
   output logic                         flush,
   output logic [WIDTH_DATA_LENGTH-1:0] redirect_pc,
   output logic [CNT_W-1:0]             branch_cnt,
   output logic [CNT_W-1:0]             miss_cnt
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int SH_W  = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state_q, state_d;
   logic [SH_W-1:0]   shadow_q, shadow_d;
   logic              resolve, dir_miss, tgt_miss, miss;
   logic [1:0]        res_d;
   logic              unused_if_bits;

   // Only the word-index bits of the fetch PC select a counter.
   assign unused_if_bits = ^{if_pc[WIDTH_DATA_LENGTH-1:IDX_W+2], if_pc[1:0]};

   assign resolve  = ex_valid & ex_is_branch & (state_q == IDLE);
   assign dir_miss = ex_predicted != ex_taken;
   assign tgt_miss = ex_taken & (ex_pc_pre != ex_pc_alu);
   assign miss     = resolve & (dir_miss | tgt_miss);

   bht_counter_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W),
      .BYPASS(BYPASS)
   ) u_table (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (if_pc[IDX_W+1:2]),
      .rd_taken (pred_taken),
      .upd_en   (resolve),
      .upd_idx  (ex_pc[IDX_W+1:2]),
      .upd_taken(ex_taken)
   );

   always_comb begin
      res_d = RES_NONE;
      if (resolve) begin
         if (dir_miss)      res_d = RES_MISS_DIR;
         else if (tgt_miss) res_d = RES_MISS_TGT;
         else               res_d = RES_HIT;
      end
   end

   // The shadow starts on the flush cycle itself, so FLUSH_CYC resolves
   // following the mispredicted branch are dropped as wrong-path work.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      case (state_q)
         IDLE: begin
            if (miss && (FLUSH_CYC > 0)) begin
               state_d  = SHADOW;
               shadow_d = SH_W'(FLUSH_CYC);
            end
         end
         SHADOW: begin
            shadow_d = shadow_q - SH_W'(1);
            if (shadow_q == SH_W'(1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         shadow_q <= '0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result      <= RES_NONE;
         flush       <= 1'b0;
         redirect_pc <= '0;
      end else begin
         result <= res_d;
         flush  <= miss;
         if (miss) redirect_pc <= ex_taken ? ex_pc_alu : ex_pc + WIDTH_DATA_LENGTH'(4);
      end
   end

   // Clear wins over a same-cycle increment; both counters stick at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt <= '0;
         miss_cnt   <= '0;
      end else if (stat_clr) begin
         branch_cnt <= '0;
         miss_cnt   <= '0;
      end else begin
         if (resolve && (branch_cnt != CNT_MAX)) branch_cnt <= branch_cnt + CNT_W'(1);
         if (miss && (miss_cnt != CNT_MAX))      miss_cnt   <= miss_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Table-driven bench for branch_resolve_bht: a default instance and a
// BYPASS=1 / CNT_W=2 instance share stimulus and are checked side by side.
module tb_branch_resolve_bht;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  if_pc, ex_pc, ex_pc_pre, ex_pc_alu;
   logic          ex_valid, ex_is_branch, ex_predicted, ex_taken, stat_clr;
   logic          pred_a, pred_b, flush_a, flush_b;
   logic [1:0]    result_a, result_b;
   logic [W-1:0]  redir_a, redir_b;
   logic [15:0]   bcnt_a, mcnt_a;
   logic [1:0]    bcnt_b, mcnt_b;
   int            checks = 0;
   int            failures = 0;

   always #5 clk = ~clk;

   typedef struct {
      logic          valid;
      logic          is_br;
      logic [W-1:0]  pc;
      logic          pred;
      logic [W-1:0]  pc_pre;
      logic [W-1:0]  pc_alu;
      logic          taken;
      logic          clr;
      logic [W-1:0]  fetch_pc;
      logic          exp_pa;
      logic          exp_pb;
      logic [1:0]    exp_res;
      logic          exp_flush;
      logic [W-1:0]  exp_redir;
      logic [15:0]   exp_bcnt;
      logic [15:0]   exp_mcnt;
   } vec_t;

   vec_t vecs[$];

   branch_resolve_bht #(
      .WIDTH_DATA_LENGTH(W), .DEPTH(64), .FLUSH_CYC(2), .BYPASS(0), .CNT_W(16)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_a),
      .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
      .ex_predicted(ex_predicted), .ex_pc_pre(ex_pc_pre), .ex_pc_alu(ex_pc_alu),
      .ex_taken(ex_taken), .stat_clr(stat_clr), .result(result_a), .flush(flush_a),
      .redirect_pc(redir_a), .branch_cnt(bcnt_a), .miss_cnt(mcnt_a)
   );

   branch_resolve_bht #(
      .WIDTH_DATA_LENGTH(W), .DEPTH(64), .FLUSH_CYC(2), .BYPASS(1), .CNT_W(2)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_b),
      .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
      .ex_predicted(ex_predicted), .ex_pc_pre(ex_pc_pre), .ex_pc_alu(ex_pc_alu),
      .ex_taken(ex_taken), .stat_clr(stat_clr), .result(result_b), .flush(flush_b),
      .redirect_pc(redir_b), .branch_cnt(bcnt_b), .miss_cnt(mcnt_b)
   );

   function automatic vec_t mkVec(logic v, logic b, logic [W-1:0] pc, logic p,
                                  logic [W-1:0] pre, logic [W-1:0] alu, logic t,
                                  logic c, logic [W-1:0] fpc, logic pa, logic pb,
                                  logic [1:0] r, logic f, logic [W-1:0] rd,
                                  logic [15:0] bc, logic [15:0] mc);
      vec_t x;
      x.valid = v; x.is_br = b; x.pc = pc; x.pred = p; x.pc_pre = pre;
      x.pc_alu = alu; x.taken = t; x.clr = c; x.fetch_pc = fpc;
      x.exp_pa = pa; x.exp_pb = pb; x.exp_res = r; x.exp_flush = f;
      x.exp_redir = rd; x.exp_bcnt = bc; x.exp_mcnt = mc;
      return x;
   endfunction

   // A 2-bit statistics counter saturates at 3.
   function automatic logic [31:0] sat3(logic [15:0] v);
      return (v > 16'd3) ? 32'd3 : {16'd0, v};
   endfunction

   task automatic applyStimulus(input vec_t x);
      @(negedge clk);
      ex_valid = x.valid; ex_is_branch = x.is_br; ex_pc = x.pc;
      ex_predicted = x.pred; ex_pc_pre = x.pc_pre; ex_pc_alu = x.pc_alu;
      ex_taken = x.taken; stat_clr = x.clr; if_pc = x.fetch_pc;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkAll(input string tag, input logic [1:0] r, input logic f,
                           input logic [W-1:0] rd, input logic [15:0] bc, input logic [15:0] mc);
      checkOutput({tag, " result_a"}, {30'd0, result_a}, {30'd0, r});
      checkOutput({tag, " result_b"}, {30'd0, result_b}, {30'd0, r});
      checkOutput({tag, " flush_a"},  {31'd0, flush_a},  {31'd0, f});
      checkOutput({tag, " flush_b"},  {31'd0, flush_b},  {31'd0, f});
      checkOutput({tag, " redir_a"},  redir_a, rd);
      checkOutput({tag, " redir_b"},  redir_b, rd);
      checkOutput({tag, " bcnt_a"},   {16'd0, bcnt_a}, {16'd0, bc});
      checkOutput({tag, " mcnt_a"},   {16'd0, mcnt_a}, {16'd0, mc});
      checkOutput({tag, " bcnt_b"},   {30'd0, bcnt_b}, sat3(bc));
      checkOutput({tag, " mcnt_b"},   {30'd0, mcnt_b}, sat3(mc));
   endtask

   initial begin
      //                valid br  ex_pc         pred pc_pre        pc_alu        tkn clr if_pc         pa   pb   res    fl   redirect      bcnt mcnt
      vecs.push_back(mkVec(0, 0, 32'h0,         0, 32'h0,         32'h0,        0, 0, 32'h0,         0, 0, 2'b00, 0, 32'h0,         0, 0));
      vecs.push_back(mkVec(0, 0, 32'h0,         0, 32'h0,         32'h0,        0, 0, 32'h10,        0, 0, 2'b00, 0, 32'h0,         0, 0));
      vecs.push_back(mkVec(1, 1, 32'h1234_0000, 0, 32'h0,         32'h0,        0, 0, 32'h1234_0000, 0, 0, 2'b01, 0, 32'h0,         1, 0));
      vecs.push_back(mkVec(1, 1, 32'h1234_0000, 0, 32'h0,         32'h0,        0, 0, 32'h1234_0000, 0, 0, 2'b01, 0, 32'h0,         2, 0));
      vecs.push_back(mkVec(1, 1, 32'h20,        1, 32'h1234_0000, 32'h1234_FFFF, 1, 0, 32'h20,       0, 1, 2'b11, 1, 32'h1234_FFFF, 3, 1));
      vecs.push_back(mkVec(1, 1, 32'h10,        0, 32'h0,         32'h0,        1, 0, 32'h10,        0, 0, 2'b00, 0, 32'h1234_FFFF, 3, 1));
      vecs.push_back(mkVec(1, 1, 32'h10,        0, 32'h0,         32'h0,        1, 0, 32'h10,        0, 0, 2'b00, 0, 32'h1234_FFFF, 3, 1));
      vecs.push_back(mkVec(1, 1, 32'h10,        1, 32'h40,        32'h40,       1, 0, 32'h10,        0, 1, 2'b01, 0, 32'h1234_FFFF, 4, 1));
      vecs.push_back(mkVec(0, 0, 32'h0,         0, 32'h0,         32'h0,        0, 0, 32'h10,        1, 1, 2'b00, 0, 32'h1234_FFFF, 4, 1));
      vecs.push_back(mkVec(1, 1, 32'h10,        1, 32'h40,        32'h40,       1, 0, 32'h10,        1, 1, 2'b01, 0, 32'h1234_FFFF, 5, 1));
      vecs.push_back(mkVec(1, 1, 32'h10,        1, 32'h40,        32'h40,       1, 0, 32'h10,        1, 1, 2'b01, 0, 32'h1234_FFFF, 6, 1));
      vecs.push_back(mkVec(1, 1, 32'hFFFF_FFFC, 1, 32'h500,       32'h500,      0, 0, 32'hFFFF_FFFC, 0, 0, 2'b10, 1, 32'h0,         7, 2));
      vecs.push_back(mkVec(0, 0, 32'h0,         0, 32'h0,         32'h0,        0, 0, 32'h1234_0000, 0, 0, 2'b00, 0, 32'h0,         7, 2));
      vecs.push_back(mkVec(0, 0, 32'h0,         0, 32'h0,         32'h0,        0, 0, 32'hFFFF_FFFC, 0, 0, 2'b00, 0, 32'h0,         7, 2));
      vecs.push_back(mkVec(1, 1, 32'h30,        0, 32'h0,         32'h0,        0, 1, 32'h10,        1, 1, 2'b01, 0, 32'h0,         0, 0));
      vecs.push_back(mkVec(1, 1, 32'h40,        0, 32'h0,         32'h8000,     1, 0, 32'h40,        0, 1, 2'b10, 1, 32'h8000,      1, 1));
      vecs.push_back(mkVec(0, 0, 32'h0,         0, 32'h0,         32'h0,        0, 0, 32'h20,        1, 1, 2'b00, 0, 32'h8000,      1, 1));
      vecs.push_back(mkVec(0, 0, 32'h0,         0, 32'h0,         32'h0,        0, 0, 32'h20,        1, 1, 2'b00, 0, 32'h8000,      1, 1));
      vecs.push_back(mkVec(1, 1, 32'h50,        0, 32'h1,         32'h2,        0, 0, 32'h50,        0, 0, 2'b01, 0, 32'h8000,      2, 1));

      rst_n = 1'b0;
      ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = '0; ex_predicted = 1'b0;
      ex_pc_pre = '0; ex_pc_alu = '0; ex_taken = 1'b0; stat_clr = 1'b0; if_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      checkAll("reset", 2'b00, 1'b0, 32'h0, 16'd0, 16'd0);
      for (int i = 0; i < 64; i++) begin
         if_pc = 32'(i * 4);
         #1;
         checkOutput($sformatf("reset pred_a idx%0d", i), {31'd0, pred_a}, 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         #2;
         checkOutput($sformatf("v%0d pred_a", i), {31'd0, pred_a}, {31'd0, vecs[i].exp_pa});
         checkOutput($sformatf("v%0d pred_b", i), {31'd0, pred_b}, {31'd0, vecs[i].exp_pb});
         @(posedge clk);
         #1;
         checkAll($sformatf("v%0d", i), vecs[i].exp_res, vecs[i].exp_flush,
                  vecs[i].exp_redir, vecs[i].exp_bcnt, vecs[i].exp_mcnt);
      end

      // Direction miss on entry 4 (currently strongly taken) opens a shadow window.
      applyStimulus(mkVec(1, 1, 32'h10, 1, 32'h0, 32'h0, 0, 0, 32'h10,
                          1, 1, 2'b10, 1, 32'h14, 3, 2));
      @(posedge clk);
      #1;
      checkAll("pre_rst", 2'b10, 1'b1, 32'h14, 16'd3, 16'd2);

      // Asynchronous reset in the middle of the shadow window.
      ex_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      checkAll("mid_rst", 2'b00, 1'b0, 32'h0, 16'd0, 16'd0);
      checkOutput("mid_rst pred_a", {31'd0, pred_a}, 32'd0);
      checkOutput("mid_rst pred_b", {31'd0, pred_b}, 32'd0);

      // First resolve after reset must be classified, not masked.
      @(negedge clk);
      rst_n = 1'b1;
      ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h10; ex_predicted = 1'b0;
      ex_taken = 1'b0; ex_pc_pre = '0; ex_pc_alu = '0; stat_clr = 1'b0; if_pc = 32'h10;
      @(posedge clk);
      #1;
      checkAll("post_rst", 2'b01, 1'b0, 32'h0, 16'd1, 16'd0);

      @(negedge clk);
      ex_valid = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_resolve_bht.md
Name: branch_resolve_bht

Overview:
Parametrised successor to the branch result checker in the RISC-V pipeline. It holds a DEPTH-entry table of 2-bit saturating counters that gives fetch a direction prediction. It classifies each executed branch as hit, direction miss or target miss, and raises a one-cycle flush with a redirect PC. After a flush it masks a programmable number of wrong-path resolves, and it keeps saturating branch and miss statistics.

Parameters:
WIDTH_DATA_LENGTH, 32, PC/data width
DEPTH, 64, counter table entries (power of 2, ≥2); IDX_W = log2(DEPTH)
FLUSH_CYC, 2, cycles of resolve masking after a flush (0 = no masking)
BYPASS, 0, 1 = same-cycle table update is forwarded to the fetch lookup
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
if_pc  in  WIDTH_DATA_LENGTH  fetch PC for lookup
pred_taken  out  1  combinational prediction: MSB of entry if_pc[IDX_W+1:2]
ex_valid  in  1  execute stage holds a valid instruction (Execute)
ex_is_branch  in  1  instruction is a conditional branch
ex_pc  in  WIDTH_DATA_LENGTH  PC of the executing branch
ex_predicted  in  1  direction predicted at fetch (Predicted)
ex_pc_pre  in  WIDTH_DATA_LENGTH  target predicted at fetch (PC_Pre)
ex_pc_alu  in  WIDTH_DATA_LENGTH  target computed by the ALU (PC_ALU)
ex_taken  in  1  actual direction
stat_clr  in  1  synchronous clear of the statistics counters
result  out  2  registered classification, encoded per package
flush  out  1  registered one-cycle mispredict pulse
redirect_pc  out  WIDTH_DATA_LENGTH  correct next PC, valid while flush=1
branch_cnt  out  CNT_W  classified branches
miss_cnt  out  CNT_W  mispredicts

Behaviour:
- Reset: all table entries 2'b01 (weakly not-taken); FSM IDLE; result=RES_NONE; flush=0; redirect_pc=0; both counters 0. Reset asserted mid-flush aborts the flush immediately.
- Resolve event: ex_valid & ex_is_branch & state==IDLE. Anything else gives RES_NONE, no table update, no statistics change.
- Classification, registered with 1-cycle latency:
  - ex_predicted≠ex_taken → RES_MISS_DIR
  - else ex_taken & (ex_pc_pre≠ex_pc_alu) → RES_MISS_TGT
  - else → RES_HIT
- Flush and redirect:
  - Any miss sets flush=1 for exactly one cycle.
  - redirect_pc = ex_taken ? ex_pc_alu : ex_pc+4 (mod 2^WIDTH, wraps).
  - On non-flush cycles redirect_pc holds its last value.
- Table update on a resolve event, entry ex_pc[IDX_W+1:2]:
  - taken: increment, saturating at 11
  - not taken: decrement, saturating at 00
  - Written at the clock edge.
  - If the fetch index equals the update index in the same cycle, pred_taken shows the old value when BYPASS=0 and the new value's MSB when BYPASS=1.
- FSM:
  - IDLE → SHADOW when a miss registers and FLUSH_CYC>0; a down-counter is loaded with FLUSH_CYC.
  - SHADOW masks resolves for FLUSH_CYC cycles following the flush cycle, then returns to IDLE.
  - A miss cannot occur in SHADOW, because resolves are masked.
  - With FLUSH_CYC=0 the FSM stays in IDLE, so back-to-back misses each flush.
- Statistics:
  - branch_cnt +1 per resolve event; miss_cnt +1 per miss.
  - Both saturate at all-ones and do not wrap.
  - stat_clr has priority over a same-cycle increment and does not affect the table.

Decomposition:
- Package branch_pkg holds: result encodings RES_NONE=2'b00, RES_HIT=2'b01, RES_MISS_DIR=2'b10, RES_MISS_TGT=2'b11; counter constants SNT=00, WNT=01, WT=10, ST=11; FSM state typedef {IDLE, SHADOW}.
- Sub-module bht_counter_array contains the counter table, read port, update port and BYPASS forwarding. Classification, FSM and statistics remain in the top module.

Test Plan:
- Reset, then ex_valid=0 → result=00, flush=0, pred_taken=0 for every if_pc, counters 0.
- Branch ex_pc=32'h1234_0000, predicted=0, taken=0 → next cycle result=01, no flush, branch_cnt=1; entry stays at 00 saturating after a second identical resolve.
- predicted=1, taken=1, PC_Pre=32'h1234_0000, PC_ALU=32'h1234_FFFF → result=11, one-cycle flush, redirect_pc=32'h1234_FFFF, miss_cnt=1; with FLUSH_CYC=2 a resolve in each of the next 2 cycles gives result=00 and counters unchanged; the 3rd resolve is classified.
- predicted=0, taken=0 is not a miss; predicted=1, taken=0 at ex_pc=32'hFFFF_FFFC → result=10, redirect_pc=32'h0000_0000 (wrap).
- Three taken resolves at ex_pc=32'h0000_0010 → entry 4 goes 01→10→11→11; pred_taken for if_pc=32'h0000_0010 goes 1 after the first update. A same-cycle lookup shows 0 with BYPASS=0 and 1 with BYPASS=1.
- CNT_W=2: four resolves → branch_cnt saturates at 3; stat_clr with a simultaneous resolve → 0. Reset asserted during SHADOW → IDLE, outputs 0, table back to 01.
